// File: rtl/bin_mult_result_collector_pkg.sv
// bin_mult_pkg
//   Shared constants for the binary-multiplier Wishbone blocks: register
//   offsets within a block's window, CTRL bit positions and the default
//   popcount/accumulator widths.
//   Also used by wb_top_bin_mult, so keep it free of block-specific logic.
package bin_mult_pkg;

    localparam int CNT_W_DEF = 7;
    localparam int ACC_W_DEF = 12;

    // Byte offsets from the block's base address
    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_CHUNKS = 5'h04;
    localparam logic [4:0] REG_THRESH = 5'h08;
    localparam logic [4:0] REG_STATUS = 5'h0C;
    localparam logic [4:0] REG_RESULT = 5'h10;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;  // write-1, self-clearing
    localparam int CTRL_FLUSH  = 2;  // write-1, self-clearing
    localparam int CTRL_IRQ_EN = 3;

    // True when a 5-bit offset lands on one of the implemented registers
    function automatic logic is_reg_offset(input logic [4:0] off);
        return (off == REG_CTRL) || (off == REG_CHUNKS) || (off == REG_THRESH) ||
               (off == REG_STATUS) || (off == REG_RESULT);
    endfunction

endpackage

// File: rtl/bin_mult_result_collector_if.sv
// bin_mult_result_collector_if
//   Classic Wishbone slave bus as seen by the result collector.
//   master modport: the Caravel Wishbone master (or a bench) drives requests.
//   slave  modport: the collector returns ack and read data.
interface bin_mult_result_collector_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/bin_mult_result_collector_fifo.sv
// bm_sync_fifo
//   Small synchronous FIFO for packed activation words.
//   Ports: clk, reset (sync, active-high), clear (sync flush of contents),
//          push/push_data, pop, head (current front word), full, empty, count.
//   A pop on an empty FIFO is ignored. When full, a simultaneous pop frees
//   the slot first so the push is accepted and count stays the same.
module bm_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is not reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/bin_mult_result_collector.sv
// bin_mult_result_collector
//   Downstream stage of the binary multiplier. Accumulates CHUNKS popcount
//   results per neuron, thresholds the sum into one activation bit, packs 32
//   bits per word and queues the words for readback over Wishbone.
//   Ports: clk, reset (sync, active-high)
//          in_valid/in_cnt   popcount results from the multiplier controller
//          wb                Wishbone slave (register window at BASE_ADDRESS)
//          act_valid_o/act_o one-cycle activation pulse and its bit
//          irq_o             FIFO non-empty and CTRL.irq_en
module bin_mult_result_collector
    import bin_mult_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0010,
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int          ACC_W        = ACC_W_DEF,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CNT_W-1:0]             in_cnt,
    bin_mult_result_collector_if.slave   wb,
    output logic                         act_valid_o,
    output logic                         act_o,
    output logic                         irq_o
);
    localparam logic [0:0] WB_IDLE = 1'b0;
    localparam logic [0:0] WB_ACK  = 1'b1;

    // ---------------- registers ----------------
    logic [0:0]       wb_state_reg;
    logic [31:0]      rdata_reg;
    logic             enable_reg, irq_en_reg, overflow_reg;
    logic [7:0]       chunks_reg;
    logic [ACC_W-1:0] thresh_reg;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [7:0]       chunk_cnt_reg, chunk_cnt_next;
    logic [4:0]       bit_idx_reg, bit_idx_next;
    logic [31:0]      pack_reg, pack_next;
    logic             act_valid_reg, act_reg;

    // ---------------- Wishbone decode ----------------
    logic [31:0] offset;
    logic [4:0]  reg_sel;
    logic        addr_hit, accept, wr_en, rd_en;
    logic        clear, flush, pop_req;

    assign offset   = wb.wb_adr_i - BASE_ADDRESS;
    assign reg_sel  = offset[4:0];
    assign addr_hit = (offset[31:5] == '0) && is_reg_offset(reg_sel);
    // Only accept from IDLE: the cycle after an ack can never ack again
    assign accept   = wb.wb_stb_i && wb.wb_cyc_i && addr_hit && (wb_state_reg == WB_IDLE);
    assign wr_en    = accept && wb.wb_we_i;
    assign rd_en    = accept && !wb.wb_we_i;
    assign clear    = wr_en && (reg_sel == REG_CTRL) && wb.wb_dat_i[CTRL_CLEAR];
    assign flush    = wr_en && (reg_sel == REG_CTRL) && wb.wb_dat_i[CTRL_FLUSH] && !clear;
    assign pop_req  = rd_en && (reg_sel == REG_RESULT);

    // Bits of the write bus no register implements
    logic unused_dat;
    assign unused_dat = &{1'b0, wb.wb_dat_i[31:ACC_W]};

    // ---------------- FIFO ----------------
    logic                        push;
    logic [31:0]                 push_word;
    logic [31:0]                 fifo_head;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    bm_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push && !clear),
        .push_data (push_word),
        .pop       (pop_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- accumulate / threshold / pack ----------------
    logic [7:0]     chunks_eff;
    logic [ACC_W:0] sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic           step, last_chunk, act_bit, act_fire;

    assign chunks_eff = (chunks_reg == 8'd0) ? 8'd1 : chunks_reg;
    assign sum_wide   = {1'b0, acc_reg} + {{(ACC_W+1-CNT_W){1'b0}}, in_cnt};
    assign sum_sat    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign step       = enable_reg && in_valid && !clear;
    // ">=" so that shrinking CHUNKS mid-neuron completes on the next input
    assign last_chunk = (chunk_cnt_reg >= (chunks_eff - 8'd1));
    assign act_bit    = (sum_sat >= thresh_reg);
    assign act_fire   = step && last_chunk;

    always_comb begin
        acc_next       = acc_reg;
        chunk_cnt_next = chunk_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        pack_next      = pack_reg;
        push           = 1'b0;
        push_word      = pack_reg;
        if (step) begin
            if (last_chunk) begin
                acc_next       = '0;
                chunk_cnt_next = '0;
                pack_next[bit_idx_reg] = act_bit;
                bit_idx_next   = bit_idx_reg + 5'd1;
                if (bit_idx_reg == 5'd31) begin
                    push      = 1'b1;
                    push_word = pack_next;
                    pack_next = '0;
                end
            end else begin
                acc_next       = sum_sat;
                chunk_cnt_next = chunk_cnt_reg + 8'd1;
            end
        end
        // Flush sees the word including any bit completed this cycle; after a
        // wrap bit_idx_next is already 0 so flush is a no-op then.
        if (flush && (bit_idx_next != 5'd0)) begin
            push         = 1'b1;
            push_word    = pack_next;
            pack_next    = '0;
            bit_idx_next = '0;
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CTRL:   rd_mux = {28'd0, irq_en_reg, 2'b00, enable_reg};
            REG_CHUNKS: rd_mux = {24'd0, chunks_reg};
            REG_THRESH: rd_mux = {{(32-ACC_W){1'b0}}, thresh_reg};
            REG_STATUS: rd_mux = {19'd0, bit_idx_reg, 1'b0, overflow_reg,
                                  fifo_full, fifo_empty, 4'(fifo_count)};
            REG_RESULT: rd_mux = fifo_empty ? 32'd0 : fifo_head;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_state_reg  <= WB_IDLE;
            rdata_reg     <= '0;
            enable_reg    <= 1'b0;
            irq_en_reg    <= 1'b0;
            chunks_reg    <= 8'd1;
            thresh_reg    <= '0;
            overflow_reg  <= 1'b0;
            acc_reg       <= '0;
            chunk_cnt_reg <= '0;
            bit_idx_reg   <= '0;
            pack_reg      <= '0;
            act_valid_reg <= 1'b0;
            act_reg       <= 1'b0;
        end else begin
            wb_state_reg <= accept ? WB_ACK : WB_IDLE;
            rdata_reg    <= rd_en ? rd_mux : 32'd0;

            if (wr_en && (reg_sel == REG_CTRL)) begin
                enable_reg <= wb.wb_dat_i[CTRL_ENABLE];
                irq_en_reg <= wb.wb_dat_i[CTRL_IRQ_EN];
            end
            if (wr_en && (reg_sel == REG_CHUNKS)) begin
                chunks_reg <= wb.wb_dat_i[7:0];
            end
            if (wr_en && (reg_sel == REG_THRESH)) begin
                thresh_reg <= wb.wb_dat_i[ACC_W-1:0];
            end

            if (clear) begin
                overflow_reg <= 1'b0;
            end else if (push && fifo_full && !pop_req) begin
                overflow_reg <= 1'b1;
            end else if (rd_en && (reg_sel == REG_STATUS)) begin
                overflow_reg <= 1'b0;
            end

            if (clear) begin
                acc_reg       <= '0;
                chunk_cnt_reg <= '0;
                bit_idx_reg   <= '0;
                pack_reg      <= '0;
            end else begin
                acc_reg       <= acc_next;
                chunk_cnt_reg <= chunk_cnt_next;
                bit_idx_reg   <= bit_idx_next;
                pack_reg      <= pack_next;
            end

            act_valid_reg <= act_fire;
            act_reg       <= act_fire && act_bit;
        end
    end

    assign wb.wb_ack_o = (wb_state_reg == WB_ACK);
    assign wb.wb_dat_o = rdata_reg;
    assign act_valid_o = act_valid_reg;
    assign act_o       = act_reg;
    assign irq_o       = irq_en_reg && !fifo_empty;
endmodule

// File: tb/tb_bin_mult_result_collector.sv
// tb_bin_mult_result_collector
//   Directed bench for the result collector: Wishbone register access,
//   accumulate/threshold/pack, flush, overflow, pop/push collision,
//   saturation, mid-neuron CHUNKS change, clear and reset.
module tb_bin_mult_result_collector;
    localparam logic [31:0] BASE     = 32'h3000_0010;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_CHUNKS = BASE + 32'h04;
    localparam logic [31:0] A_THRESH = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_RESULT = BASE + 32'h10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_cnt = '0;
    logic       act_valid_o, act_o, irq_o;

    bin_mult_result_collector_if wb();

    bin_mult_result_collector #(
        .BASE_ADDRESS(BASE), .CNT_W(7), .ACC_W(12), .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_cnt      (in_cnt),
        .wb          (wb),
        .act_valid_o (act_valid_o),
        .act_o       (act_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Activation monitor
    int          act_count = 0;
    logic [31:0] act_hist = '0;
    always @(negedge clk) begin
        if (act_valid_o) begin
            act_count = act_count + 1;
            act_hist  = {act_hist[30:0], act_o};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One Wishbone transfer; lat = cycles to ack (0 = no ack within bound)
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        int   k;
        logic got;
        k = 0; got = 1'b0; rd = '0;
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr;  wb.wb_dat_i = wd;
        while (!got && k < 4) begin
            @(negedge clk);
            k++;
            if (wb.wb_ack_o) begin
                got = 1'b1;
                rd  = wb.wb_dat_o;
            end
        end
        lat = got ? k : 0;
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge clk);
        $display("wb %s adr=0x%08h data=0x%08h lat=%0d", we ? "wr" : "rd", adr, we ? wd : rd, lat);
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, adr, wd, rd, lat);
        check_val("wr_ack_lat", 32'(lat), 32'd1);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b0, adr, 32'd0, rd, lat);
        check_val(tag, rd, exp);
    endtask

    task automatic feed(input logic [6:0] cnt);
        in_valid = 1'b1;
        in_cnt   = cnt;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int base;

        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0;   wb.wb_dat_i = '0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // ---- 1: reset state ----
        check_val("t1_act_valid", 32'(act_valid_o), 32'd0);
        check_val("t1_irq", 32'(irq_o), 32'd0);
        check_val("t1_ack", 32'(wb.wb_ack_o), 32'd0);
        wb_xfer(1'b0, A_STATUS, 32'd0, rd, lat);
        check_val("t1_status", rd, 32'h10);
        check_val("t1_ack_lat", 32'(lat), 32'd1);
        wb_rd_chk("t1_result", A_RESULT, 32'd0);
        wb_rd_chk("t1_chunks", A_CHUNKS, 32'd1);
        wb_xfer(1'b0, BASE + 32'h14, 32'd0, rd, lat);
        check_val("t1_unmapped_hi", 32'(lat), 32'd0);
        wb_xfer(1'b0, BASE - 32'h4, 32'd0, rd, lat);
        check_val("t1_unmapped_lo", 32'(lat), 32'd0);

        // ---- 2: CHUNKS=2, THRESH=100, alternating acts ----
        wb_wr(A_CHUNKS, 32'd2);
        wb_wr(A_THRESH, 32'd100);
        wb_wr(A_CTRL, 32'h9);
        base = act_count;
        for (int i = 0; i < 16; i++) begin
            feed(7'd60); feed(7'd50); feed(7'd40); feed(7'd40);
        end
        idle(2);
        check_val("t2_act_count", 32'(act_count - base), 32'd32);
        check_val("t2_act_hist", act_hist, 32'hAAAA_AAAA);
        check_val("t2_irq_set", 32'(irq_o), 32'd1);
        wb_rd_chk("t2_status", A_STATUS, 32'h01);
        wb_rd_chk("t2_result", A_RESULT, 32'h5555_5555);
        check_val("t2_irq_clr", 32'(irq_o), 32'd0);
        wb_rd_chk("t2_status_empty", A_STATUS, 32'h10);

        // ---- 3: flush of a partial word ----
        wb_wr(A_CTRL, 32'h3);
        wb_wr(A_CHUNKS, 32'd1);
        wb_wr(A_THRESH, 32'd0);
        feed(7'd0);
        check_val("t3_act_valid_lat", 32'(act_valid_o), 32'd1);
        check_val("t3_act_bit", 32'(act_o), 32'd1);
        for (int i = 0; i < 4; i++) feed(7'd0);
        idle(1);
        wb_rd_chk("t3_status_bidx", A_STATUS, 32'h510);
        wb_wr(A_CTRL, 32'h5);
        wb_rd_chk("t3_result", A_RESULT, 32'h0000_001F);
        wb_rd_chk("t3_status", A_STATUS, 32'h10);
        wb_rd_chk("t3_result_empty", A_RESULT, 32'd0);

        // ---- 4: overflow with 5 words, FIFO_DEPTH=4 ----
        for (int i = 0; i < 160; i++) feed(7'd3);
        idle(2);
        wb_rd_chk("t4_status_ovf", A_STATUS, 32'h64);
        wb_rd_chk("t4_status_ovf_clr", A_STATUS, 32'h24);
        for (int i = 0; i < 4; i++) wb_rd_chk("t4_result", A_RESULT, 32'hFFFF_FFFF);
        wb_rd_chk("t4_status_empty", A_STATUS, 32'h10);

        // ---- 5: RESULT pop collides with push into a full FIFO ----
        for (int i = 0; i < 159; i++) feed(7'd1);
        idle(1);
        wb_rd_chk("t5_status_pre", A_STATUS, 32'h1F24);
        in_valid = 1'b1; in_cnt = 7'd1;
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = A_RESULT;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("t5_ack", 32'(wb.wb_ack_o), 32'd1);
        check_val("t5_result", wb.wb_dat_o, 32'hFFFF_FFFF);
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
        @(negedge clk);
        $display("wb rd adr=0x%08h collided with word push", A_RESULT);
        wb_rd_chk("t5_status_post", A_STATUS, 32'h24);
        wb_wr(A_CTRL, 32'h5);
        wb_rd_chk("t5_flush_noop", A_STATUS, 32'h24);

        // ---- 6: CHUNKS=0, saturation, CHUNKS change, clear ----
        wb_wr(A_CTRL, 32'h3);
        wb_rd_chk("t6_status_clr", A_STATUS, 32'h10);
        wb_wr(A_CHUNKS, 32'd0);
        wb_wr(A_THRESH, 32'd4095);
        base = act_count;
        feed(7'd127);
        idle(2);
        check_val("t6_chunks0_count", 32'(act_count - base), 32'd1);
        check_val("t6_chunks0_act", 32'(act_hist[0]), 32'd0);
        wb_wr(A_CHUNKS, 32'd255);
        base = act_count;
        for (int i = 0; i < 32; i++) feed(7'd127);
        idle(2);
        check_val("t6_no_act_32", 32'(act_count - base), 32'd0);
        wb_wr(A_CHUNKS, 32'd33);
        feed(7'd127);
        idle(2);
        check_val("t6_act_33_count", 32'(act_count - base), 32'd1);
        check_val("t6_sat_act", 32'(act_hist[0]), 32'd1);

        wb_wr(A_THRESH, 32'd3301);
        for (int i = 0; i < 10; i++) feed(7'd100);
        in_valid = 1'b1; in_cnt = 7'd100;
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = A_CTRL; wb.wb_dat_i = 32'h3;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("t6_clear_ack", 32'(wb.wb_ack_o), 32'd1);
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge clk);
        $display("wb wr adr=0x%08h data=0x00000003 with in_valid", A_CTRL);
        base = act_count;
        for (int i = 0; i < 32; i++) feed(7'd100);
        idle(2);
        check_val("t6_clear_chunkcnt", 32'(act_count - base), 32'd0);
        feed(7'd100);
        idle(2);
        check_val("t6_clear_count", 32'(act_count - base), 32'd1);
        check_val("t6_clear_acc", 32'(act_hist[0]), 32'd0);

        // ---- reset in the middle of a Wishbone cycle ----
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = A_STATUS;
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_no_ack", 32'(wb.wb_ack_o), 32'd0);
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        wb_rd_chk("rst_chunks", A_CHUNKS, 32'd1);
        wb_rd_chk("rst_thresh", A_THRESH, 32'd0);
        wb_rd_chk("rst_ctrl", A_CTRL, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
